// File: rtl/half_adder_lanes.sv
// -----------------------------------------------------------------------------
// half_adder_lanes
//
// Registered multi-lane half adder. Each lane computes its own sum and carry
// with no dependence on other lanes:
//   s = a ^ b
//   c = a & b
// The block is a bit-parallel sum/carry generation stage that feeds adder and
// compressor trees. A saturating counter records how many accepted vectors
// produced a carry in at least one lane. This counter is intended for debug.
//
// Parameters
//   WIDTH        number of independent half-adder lanes (>= 1)
//   CNT_W        width of the carry-event counter (>= 1)
//
// Ports
//   i_clk        clock; all state updates on the rising edge
//   i_rst        asynchronous, active-high reset; clears all state
//   i_valid      input vector is valid this cycle
//   i_a, i_b     operands, one bit per lane
//   i_clr        synchronous clear of o_carry_cnt; takes priority over increment
//   o_valid      o_s/o_c hold a freshly computed result this cycle
//   o_s, o_c     per-lane sum and carry, one cycle after acceptance
//   o_carry_cnt  saturating count of accepted vectors with any lane carry
// -----------------------------------------------------------------------------
module half_adder_lanes #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_clr,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_s,
  output logic [WIDTH-1:0] o_c,
  output logic [CNT_W-1:0] o_carry_cnt
);

  // Increment that holds at all-ones instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: combinational lane logic on the raw inputs.
  logic [WIDTH-1:0] s_p0;
  logic [WIDTH-1:0] c_p0;
  logic             carry_hit_p0;

  always_comb begin
    s_p0         = i_a ^ i_b;
    c_p0         = i_a & i_b;
    carry_hit_p0 = i_valid & (|c_p0);
  end

  // Stage p1: registered results, valid and carry-event counter.
  logic             vld_p1;
  logic [WIDTH-1:0] s_p1;
  logic [WIDTH-1:0] c_p1;
  logic [CNT_W-1:0] cnt_p1;

  // The result registers are also reset. Reset must drive the outputs to a
  // known zero, and it must do so without waiting for a clock edge.
  // The result registers load only when i_valid is high. This makes them hold
  // their value between vectors, and it keeps undriven operands from affecting
  // them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p1 <= 1'b0;
      s_p1   <= '0;
      c_p1   <= '0;
      cnt_p1 <= '0;
    end else begin
      vld_p1 <= i_valid;
      if (i_valid) begin
        s_p1 <= s_p0;
        c_p1 <= c_p0;
      end
      if (i_clr) begin
        cnt_p1 <= '0;
      end else if (carry_hit_p0) begin
        cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  assign o_valid     = vld_p1;
  assign o_s         = s_p1;
  assign o_c         = c_p1;
  assign o_carry_cnt = cnt_p1;

endmodule

// File: tb/tb_half_adder_lanes.sv
// -----------------------------------------------------------------------------
// tb_half_adder_lanes
//
// Directed testbench for half_adder_lanes. It uses two instances:
//   u8: WIDTH=8, CNT_W=8 (wide lanes)
//   u1: WIDTH=1, CNT_W=2 (single lane, counter saturates quickly)
// Both instances share the clock and the reset.
// -----------------------------------------------------------------------------
module tb_half_adder_lanes;

  logic       clk;
  logic       rst;

  logic       valid8, clr8, ov8;
  logic [7:0] a8, b8, s8, c8, cnt8;

  logic       valid1, clr1, ov1;
  logic [0:0] a1, b1, s1, c1;
  logic [1:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  half_adder_lanes #(.WIDTH(8), .CNT_W(8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid8), .i_a(a8), .i_b(b8),
    .i_clr(clr8), .o_valid(ov8), .o_s(s8), .o_c(c8), .o_carry_cnt(cnt8)
  );

  half_adder_lanes #(.WIDTH(1), .CNT_W(2)) u1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid1), .i_a(a1), .i_b(b1),
    .i_clr(clr1), .o_valid(ov1), .o_s(s1), .o_c(c1), .o_carry_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge. Outputs are sampled here.
  // New inputs are also driven from here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; clr8 = 1'b0;
    valid1 = 1'b1; a1 = 1'b1;  b1 = 1'b1;  clr1 = 1'b0;
    tick();
    tick();
    n_tests++; if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL reset_ov8 got %b exp 0", ov8); end
    n_tests++; if (s8 !== 8'h00)   begin n_fail++; $display("FAIL reset_s8 got %h exp 00", s8); end
    n_tests++; if (c8 !== 8'h00)   begin n_fail++; $display("FAIL reset_c8 got %h exp 00", c8); end
    n_tests++; if (cnt8 !== 8'h00) begin n_fail++; $display("FAIL reset_cnt8 got %h exp 00", cnt8); end
    n_tests++; if (ov1 !== 1'b0)   begin n_fail++; $display("FAIL reset_ov1 got %b exp 0", ov1); end
    n_tests++; if (cnt1 !== 2'd0)  begin n_fail++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
    valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    valid1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;
    rst = 1'b0;
    tick();
    n_tests++; if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL post_reset_ov8 got %b exp 0", ov8); end
  endtask

  task automatic test_truth_table();
    logic [3:0] exp_s = 4'b0110;
    logic [3:0] exp_c = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      valid1 = 1'b1;
      a1 = 1'((i >> 1) & 1);
      b1 = 1'(i & 1);
      tick();
      n_tests++; if (ov1 !== 1'b1)     begin n_fail++; $display("FAIL tt_ov vec %0d got %b exp 1", i, ov1); end
      n_tests++; if (s1 !== exp_s[i])  begin n_fail++; $display("FAIL tt_s vec %0d got %b exp %b", i, s1, exp_s[i]); end
      n_tests++; if (c1 !== exp_c[i])  begin n_fail++; $display("FAIL tt_c vec %0d got %b exp %b", i, c1, exp_c[i]); end
    end
    valid1 = 1'b0;
    tick();
    n_tests++; if (ov1 !== 1'b0)  begin n_fail++; $display("FAIL tt_ov_drop got %b exp 0", ov1); end
    n_tests++; if (cnt1 !== 2'd1) begin n_fail++; $display("FAIL tt_cnt got %0d exp 1", cnt1); end
  endtask

  task automatic test_wide();
    valid8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    tick();
    n_tests++; if (ov8 !== 1'b1)   begin n_fail++; $display("FAIL wide_ov got %b exp 1", ov8); end
    n_tests++; if (s8 !== 8'hCC)   begin n_fail++; $display("FAIL wide_s got %h exp cc", s8); end
    n_tests++; if (c8 !== 8'h30)   begin n_fail++; $display("FAIL wide_c got %h exp 30", c8); end
    n_tests++; if (cnt8 !== 8'd1)  begin n_fail++; $display("FAIL wide_cnt got %0d exp 1", cnt8); end
  endtask

  task automatic test_hold();
    valid8 = 1'b0; a8 = 'x; b8 = 'x;
    tick();
    n_tests++; if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL hold_ov got %b exp 0", ov8); end
    n_tests++; if (s8 !== 8'hCC)   begin n_fail++; $display("FAIL hold_s got %h exp cc", s8); end
    n_tests++; if (c8 !== 8'h30)   begin n_fail++; $display("FAIL hold_c got %h exp 30", c8); end
    n_tests++; if (cnt8 !== 8'd1)  begin n_fail++; $display("FAIL hold_cnt got %0d exp 1", cnt8); end
    valid8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
    tick();
    n_tests++; if (s8 !== 8'hFF)   begin n_fail++; $display("FAIL nocarry_s got %h exp ff", s8); end
    n_tests++; if (c8 !== 8'h00)   begin n_fail++; $display("FAIL nocarry_c got %h exp 00", c8); end
    n_tests++; if (cnt8 !== 8'd1)  begin n_fail++; $display("FAIL nocarry_cnt got %0d exp 1", cnt8); end
  endtask

  task automatic test_back_to_back();
    valid8 = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
    tick();
    n_tests++; if (ov8 !== 1'b1)   begin n_fail++; $display("FAIL b2b0_ov got %b exp 1", ov8); end
    n_tests++; if (s8 !== 8'hF0)   begin n_fail++; $display("FAIL b2b0_s got %h exp f0", s8); end
    n_tests++; if (c8 !== 8'h0F)   begin n_fail++; $display("FAIL b2b0_c got %h exp 0f", c8); end
    n_tests++; if (cnt8 !== 8'd2)  begin n_fail++; $display("FAIL b2b0_cnt got %0d exp 2", cnt8); end
    a8 = 8'h81; b8 = 8'h81;
    tick();
    n_tests++; if (ov8 !== 1'b1)   begin n_fail++; $display("FAIL b2b1_ov got %b exp 1", ov8); end
    n_tests++; if (s8 !== 8'h00)   begin n_fail++; $display("FAIL b2b1_s got %h exp 00", s8); end
    n_tests++; if (c8 !== 8'h81)   begin n_fail++; $display("FAIL b2b1_c got %h exp 81", c8); end
    n_tests++; if (cnt8 !== 8'd3)  begin n_fail++; $display("FAIL b2b1_cnt got %0d exp 3", cnt8); end
  endtask

  task automatic test_clear();
    valid8 = 1'b1; a8 = 8'h01; b8 = 8'h01; clr8 = 1'b1;
    tick();
    n_tests++; if (ov8 !== 1'b1)   begin n_fail++; $display("FAIL clr_ov got %b exp 1", ov8); end
    n_tests++; if (s8 !== 8'h00)   begin n_fail++; $display("FAIL clr_s got %h exp 00", s8); end
    n_tests++; if (c8 !== 8'h01)   begin n_fail++; $display("FAIL clr_c got %h exp 01", c8); end
    n_tests++; if (cnt8 !== 8'd0)  begin n_fail++; $display("FAIL clr_cnt got %0d exp 0", cnt8); end
    clr8 = 1'b0; valid8 = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clr1 = 1'b1; valid1 = 1'b0;
    tick();
    n_tests++; if (cnt1 !== 2'd0) begin n_fail++; $display("FAIL sat_preclr got %0d exp 0", cnt1); end
    clr1 = 1'b0; valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (cnt1 !== exp_cnt[i]) begin n_fail++; $display("FAIL sat_cnt vec %0d got %0d exp %0d", i, cnt1, exp_cnt[i]); end
    end
    clr1 = 1'b1;
    tick();
    n_tests++; if (cnt1 !== 2'd0) begin n_fail++; $display("FAIL sat_clr got %0d exp 0", cnt1); end
    n_tests++; if (c1 !== 1'b1)   begin n_fail++; $display("FAIL sat_clr_c got %b exp 1", c1); end
    clr1 = 1'b0; valid1 = 1'b0;
  endtask

  task automatic test_async_reset();
    valid8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    tick();
    n_tests++; if (ov8 !== 1'b1)   begin n_fail++; $display("FAIL ar_pre_ov got %b exp 1", ov8); end
    n_tests++; if (cnt8 !== 8'd1)  begin n_fail++; $display("FAIL ar_pre_cnt got %0d exp 1", cnt8); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL ar_ov got %b exp 0", ov8); end
    n_tests++; if (s8 !== 8'h00)   begin n_fail++; $display("FAIL ar_s got %h exp 00", s8); end
    n_tests++; if (c8 !== 8'h00)   begin n_fail++; $display("FAIL ar_c got %h exp 00", c8); end
    n_tests++; if (cnt8 !== 8'd0)  begin n_fail++; $display("FAIL ar_cnt got %0d exp 0", cnt8); end
    tick();
    n_tests++; if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL ar_held_ov got %b exp 0", ov8); end
    n_tests++; if (s8 !== 8'h00)   begin n_fail++; $display("FAIL ar_held_s got %h exp 00", s8); end
    rst = 1'b0;
    a8 = 8'h0F; b8 = 8'h0F;
    tick();
    n_tests++; if (ov8 !== 1'b1)   begin n_fail++; $display("FAIL ar_rec_ov got %b exp 1", ov8); end
    n_tests++; if (s8 !== 8'h00)   begin n_fail++; $display("FAIL ar_rec_s got %h exp 00", s8); end
    n_tests++; if (c8 !== 8'h0F)   begin n_fail++; $display("FAIL ar_rec_c got %h exp 0f", c8); end
    n_tests++; if (cnt8 !== 8'd1)  begin n_fail++; $display("FAIL ar_rec_cnt got %0d exp 1", cnt8); end
    valid8 = 1'b0;
    tick();
    n_tests++; if (ov8 !== 1'b0)   begin n_fail++; $display("FAIL ar_rec_drop got %b exp 0", ov8); end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_wide();
    test_hold();
    test_back_to_back();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
